// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC, issues one instruction
// fetch at a time over a req/ack port and hands words to decode via valid/ready.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   stall                         blocks issue of a new fetch request
//   branch_valid, branch_target   one-cycle redirect of the PC
//   imem_req, imem_addr           fetch request, held until imem_ack
//   imem_ack, imem_rdata          memory response
//   instr_valid, instr_out,
//   instr_pc, instr_ready         instruction handoff to decode
//   pc_out                        address of the next fetch to issue
//   misalign_err                  sticky misaligned-branch flag
//
// Build option: define BRANCH_MISALIGN_TRAP_EN to flag and ignore branch
// targets that are not INSTR_BYTES aligned. Without it the target low bits
// are cleared and misalign_err stays 0.
module pc_fetch_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                INSTR_BYTES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DELIVER
    } state_t;

    localparam logic [ADDR_W-1:0] LP_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] LP_INC  = ADDR_W'(INSTR_BYTES);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_ipc;
    logic              r_squash;
    logic              r_mis;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_valid_nxt;
    logic [31:0]       w_instr_nxt;
    logic [ADDR_W-1:0] w_ipc_nxt;
    logic              w_squash_nxt;

    logic              w_br;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_mis_set;

`ifdef BRANCH_MISALIGN_TRAP_EN
    // A misaligned redirect is dropped entirely; only the flag records it.
    assign w_mis_set = branch_valid & (|(branch_target & LP_MASK));
    assign w_br      = branch_valid & ~w_mis_set;
    assign w_tgt     = branch_target;
`else
    assign w_mis_set = 1'b0;
    assign w_br      = branch_valid;
    assign w_tgt     = branch_target & ~LP_MASK;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_VECTOR;
            r_req    <= 1'b0;
            r_addr   <= RESET_VECTOR;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_ipc    <= '0;
            r_squash <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_req    <= w_req_nxt;
            r_addr   <= w_addr_nxt;
            r_valid  <= w_valid_nxt;
            r_instr  <= w_instr_nxt;
            r_ipc    <= w_ipc_nxt;
            r_squash <= w_squash_nxt;
            r_mis    <= r_mis | w_mis_set;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_req_nxt    = r_req;
        w_addr_nxt   = r_addr;
        w_valid_nxt  = r_valid;
        w_instr_nxt  = r_instr;
        w_ipc_nxt    = r_ipc;
        w_squash_nxt = r_squash;

        unique case (r_state)
            S_IDLE: begin
                // A redirect in IDLE delays issue so the target is fetched.
                if (!w_br && !stall) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    w_req_nxt    = 1'b0;
                    w_squash_nxt = 1'b0;
                    if (r_squash || w_br) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_instr_nxt = imem_rdata;
                        w_ipc_nxt   = r_addr;
                        w_pc_nxt    = r_addr + LP_INC;
                        w_state_nxt = S_DELIVER;
                    end
                end else if (w_br) begin
                    // Request stays on the bus; its data is dropped on ack.
                    w_squash_nxt = 1'b1;
                end
            end
            S_DELIVER: begin
                if (w_br) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (instr_ready) begin
                    w_valid_nxt = 1'b0;
                    if (stall) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_pc;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_br) begin
            w_pc_nxt = w_tgt;
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign instr_valid  = r_valid;
    assign instr_out    = r_instr;
    assign instr_pc     = r_ipc;
    assign pc_out       = r_pc;
    assign misalign_err = r_mis;

endmodule
